// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   SPI-slave (mode 0) to register-file bridge. A frame is one command byte
//   (bit7 = write, low ADDR_W bits = address) followed by any number of
//   DATA_W-bit words, MSB first. Writes produce a one-cycle reg_wr per word.
//   Reads produce a one-cycle reg_rd after the command and after every
//   completed word. The returned data is shifted out on spi_miso.
//
//   Build option: define SPI_REG_BRIDGE_AUTOINC_EN to make reg_addr advance
//   (mod 2^ADDR_W) after each completed word. When it is undefined, every
//   word of a burst targets the command address.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   spi_cs_n/clk/mosi synchronised SPI inputs (mode 0)
//   spi_miso          serial read data, 0 outside read data phase
//   reg_addr/wdata    register address / write data
//   reg_wr, reg_rd    one-cycle strobes
//   reg_rdata         read data, sampled the cycle after reg_rd
//   busy              frame in progress
//   frame_abort       one-cycle pulse when cs_n rises mid-command/mid-word
module spi_reg_bridge #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_abort
);

  localparam int CNT_W = 6;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              prev_clk_q, prev_clk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_dir_q, wr_dir_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_q, load_d;     // capture reg_rdata this cycle
  logic              inc_q, inc_d;       // advance address after a write strobe
  logic              shift_en_q, shift_en_d; // next fall may shift tx_sh

  logic              rise, fall;
  logic [7:0]        cmd_byte;
  logic [DATA_W-1:0] word;

  assign rise     = spi_clk & ~prev_clk_q;
  assign fall     = ~spi_clk & prev_clk_q;
  assign cmd_byte = {rx_sh_q[6:0], spi_mosi};
  assign word     = {rx_sh_q[DATA_W-2:0], spi_mosi};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    prev_clk_d = spi_clk;
    addr_d     = addr_q;
    wr_dir_d   = wr_dir_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    wdata_d    = wdata_q;
    load_d     = rd_q;
    inc_d      = 1'b0;
    shift_en_d = shift_en_q;

    if (load_q) tx_sh_d = reg_rdata;
    if (inc_q)  addr_d  = addr_q + ADDR_STEP;

    if (state_q != IDLE && spi_cs_n) begin
      // Deassert wins over any edge seen this cycle; partial data is dropped.
      state_d    = IDLE;
      bit_cnt_d  = '0;
      shift_en_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!spi_cs_n) begin
            state_d    = CMD;
            bit_cnt_d  = '0;
            rx_sh_d    = '0;
            tx_sh_d    = '0;
            shift_en_d = 1'b0;
          end
        end
        CMD: begin
          if (rise) begin
            rx_sh_d = word;
            if (bit_cnt_q == CNT_W'(7)) begin
              addr_d    = cmd_byte[ADDR_W-1:0];
              wr_dir_d  = cmd_byte[7];
              rd_d      = ~cmd_byte[7];
              bit_cnt_d = '0;
              state_d   = DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (rise) begin
            rx_sh_d = word;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d  = '0;
              // The fall after a word's last bit must not shift: the
              // prefetched next word is loaded before it arrives.
              shift_en_d = 1'b0;
              if (wr_dir_q) begin
                wr_d    = 1'b1;
                wdata_d = word;
                inc_d   = 1'b1;
              end else begin
                // Reads advance first so the prefetch targets the next word.
                addr_d = addr_q + ADDR_STEP;
                rd_d   = 1'b1;
              end
            end else begin
              bit_cnt_d  = bit_cnt_q + CNT_W'(1);
              shift_en_d = 1'b1;
            end
          end else if (fall && shift_en_q) begin
            tx_sh_d    = {tx_sh_q[DATA_W-2:0], 1'b0};
            shift_en_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      prev_clk_q <= 1'b0;
      addr_q     <= '0;
      wr_dir_q   <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      inc_q      <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      prev_clk_q <= prev_clk_d;
      addr_q     <= addr_d;
      wr_dir_q   <= wr_dir_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      inc_q      <= inc_d;
      shift_en_q <= shift_en_d;
    end
  end

  // Strobes and status are masked by rst so a reset cycle never shows
  // an event that was already registered.
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wr      = wr_q & ~rst;
  assign reg_rd      = rd_q & ~rst;
  assign busy        = ~rst & ~spi_cs_n & (state_q != IDLE);
  assign spi_miso    = ~rst & ~spi_cs_n & (state_q == DATA) & ~wr_dir_q & tx_sh_q[DATA_W-1];
  assign frame_abort = ~rst & spi_cs_n &
                       ((state_q == CMD) || (state_q == DATA && bit_cnt_q != '0));

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int H      = 5;   // SPI half period in clk cycles
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif

  logic clk, rst, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata, reg_rdata;
  logic reg_wr, reg_rd, busy, frame_abort;

  spi_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .frame_abort(frame_abort));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral register file and event log (owned by this process only).
  logic [7:0]  mem [16];
  logic [7:0]  init_mem [16];
  logic        load_mem;
  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  int          abort_cnt = 0;

  assign reg_rdata = mem[reg_addr];

  always @(negedge clk) begin
    if (load_mem) for (int i = 0; i < 16; i++) mem[i] = init_mem[i];
    if (reg_wr) begin
      wr_q.push_back({reg_addr, reg_wdata});
      mem[reg_addr] = reg_wdata;
    end
    if (reg_rd) rd_q.push_back(reg_addr);
    if (frame_abort) abort_cnt++;
  end

  int chk_cnt = 0, pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic spi_bit(input logic m, output logic s);
    spi_mosi = m;
    repeat (H) tick();
    s = spi_miso;          // master samples just before its rising edge
    spi_clk = 1'b1;
    repeat (H) tick();
    spi_clk = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nbits, input logic [3:0][7:0] d,
                           output logic [3:0][7:0] rx, output logic ab, output logic bz,
                           output logic mi);
    logic b, s;
    rx = '0;
    spi_cs_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) b = cmd[7-i];
      else       b = d[(i-8)/8][7-((i-8)%8)];
      spi_bit(b, s);
      if (i >= 8) rx[(i-8)/8][7-((i-8)%8)] = s;
    end
    repeat (H) tick();
    spi_cs_n = 1'b1;
    #1;
    ab = frame_abort; bz = busy; mi = spi_miso;
    repeat (2*H) tick();   // one SPI period between frames
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          nbits;
    logic [7:0]  d0, d1;
    int          n_wr;
    logic [11:0] wr0, wr1;
    int          n_rd;
    logic [3:0]  rd0;
    logic [7:0]  rx0;
    logic        abort;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [3:0][7:0] d, rx;
    logic ab, bz, mi, s;
    int wb, rb, ac;
    logic [7:0] model_mem [16];

    vecs[0] = '{8'h85, 16, 8'hA5, 8'h00, 1, {4'h5, 8'hA5}, 12'h0, 0, 4'h0, 8'h00, 1'b0};
    vecs[1] = '{8'h03, 16, 8'hFF, 8'h00, 0, 12'h0, 12'h0, 2, 4'h3, 8'h3C, 1'b0};
    vecs[2] = '{8'h8F, 24, 8'h11, 8'h22, 2, {4'hF, 8'h11}, {(STEP != 0) ? 4'h0 : 4'hF, 8'h22},
                0, 4'h0, 8'h00, 1'b0};
    vecs[3] = '{8'h82, 13, 8'hF8, 8'h00, 0, 12'h0, 12'h0, 0, 4'h0, 8'h00, 1'b1};
    vecs[4] = '{8'h05, 16, 8'h00, 8'h00, 0, 12'h0, 12'h0, 2, 4'h5, 8'hA5, 1'b0};
    vecs[5] = '{8'h0F, 16, 8'h00, 8'h00, 0, 12'h0, 12'h0, 2, 4'hF,
                (STEP != 0) ? 8'h11 : 8'h22, 1'b0};
    vecs[6] = '{8'h8A, 8, 8'h00, 8'h00, 0, 12'h0, 12'h0, 0, 4'h0, 8'h00, 1'b0};
    vecs[7] = '{8'h01, 4, 8'h00, 8'h00, 0, 12'h0, 12'h0, 0, 4'h0, 8'h00, 1'b1};
    vecs[8] = '{8'h73, 16, 8'h00, 8'h00, 0, 12'h0, 12'h0, 2, 4'h3, 8'h3C, 1'b0};

    rst = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; load_mem = 1'b0;
    for (int i = 0; i < 16; i++) init_mem[i] = 8'h00;
    init_mem[3] = 8'h3C;
    load_mem = 1'b1;
    repeat (3) tick();
    load_mem = 1'b0;
    chk("reset outputs", {spi_miso, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_abort}, 0);
    rst = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a command byte.
    ac = abort_cnt;
    spi_cs_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) spi_bit(i[0], s);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("midframe reset outputs %0d", i),
          {spi_miso, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_abort}, 0);
    end
    spi_cs_n = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2*H) tick();
    chk("reset abort count", abort_cnt - ac, 0);

    for (int v = 0; v < 9; v++) begin
      wb = wr_q.size(); rb = rd_q.size(); ac = abort_cnt;
      d = '0; d[0] = vecs[v].d0; d[1] = vecs[v].d1;
      run_frame(vecs[v].cmd, vecs[v].nbits, d, rx, ab, bz, mi);
      chk($sformatf("v%0d n_wr", v), wr_q.size() - wb, vecs[v].n_wr);
      if (vecs[v].n_wr >= 1 && wr_q.size() > wb)
        chk($sformatf("v%0d wr0", v), wr_q[wb], vecs[v].wr0);
      if (vecs[v].n_wr >= 2 && wr_q.size() > wb + 1)
        chk($sformatf("v%0d wr1", v), wr_q[wb+1], vecs[v].wr1);
      chk($sformatf("v%0d n_rd", v), rd_q.size() - rb, vecs[v].n_rd);
      if (vecs[v].n_rd >= 1 && rd_q.size() > rb) begin
        chk($sformatf("v%0d rd0", v), rd_q[rb], vecs[v].rd0);
        chk($sformatf("v%0d rx0", v), rx[0], vecs[v].rx0);
      end
      chk($sformatf("v%0d abort at cs rise", v), ab, vecs[v].abort);
      chk($sformatf("v%0d abort pulses", v), abort_cnt - ac, vecs[v].abort ? 1 : 0);
      chk($sformatf("v%0d busy/miso at cs rise", v), {bz, mi}, 0);
    end

    // Randomized frames against a word-level model of the register file.
    for (int i = 0; i < 16; i++) begin
      init_mem[i]  = 8'($urandom);
      model_mem[i] = init_mem[i];
    end
    @(posedge clk); load_mem = 1'b1; tick(); load_mem = 1'b0;

    for (int f = 0; f < 30; f++) begin
      logic [7:0] cmd;
      logic [3:0] a, ea;
      int nw, nbits, part, exp_rd;
      cmd = 8'($urandom);
      a   = cmd[3:0];
      nw  = $urandom_range(0, 3);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      nbits = 8 + 8*nw + part;
      if (f % 10 == 9) nbits = $urandom_range(0, 7);   // command cut short
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      wb = wr_q.size(); rb = rd_q.size(); ac = abort_cnt;
      run_frame(cmd, nbits, d, rx, ab, bz, mi);

      nw = (nbits >= 8) ? (nbits - 8) / 8 : 0;
      if (cmd[7] || nbits < 8) begin
        chk($sformatf("r%0d n_wr", f), wr_q.size() - wb, cmd[7] ? nw : 0);
        for (int k = 0; k < nw && cmd[7]; k++) begin
          ea = a + 4'(STEP * k);
          if (wr_q.size() > wb + k)
            chk($sformatf("r%0d wr%0d", f, k), wr_q[wb+k], {ea, d[k]});
          model_mem[ea] = d[k];
        end
        chk($sformatf("r%0d n_rd", f), rd_q.size() - rb, 0);
      end else begin
        exp_rd = nw + 1;
        chk($sformatf("r%0d n_wr", f), wr_q.size() - wb, 0);
        chk($sformatf("r%0d n_rd", f), rd_q.size() - rb, exp_rd);
        for (int k = 0; k < exp_rd; k++) begin
          ea = a + 4'(STEP * k);
          if (rd_q.size() > rb + k) chk($sformatf("r%0d rd%0d", f, k), rd_q[rb+k], ea);
          if (k < nw) chk($sformatf("r%0d rx%0d", f, k), rx[k], model_mem[ea]);
        end
      end
      chk($sformatf("r%0d abort", f), {ab, 4'(abort_cnt - ac)},
          (nbits < 8 || (nbits - 8) % 8 != 0) ? 5'b1_0001 : 5'b0_0000);
      chk($sformatf("r%0d busy/miso at cs rise", f), {bz, mi}, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
